xoodoo_rdi_gen: RTL and testbench

Fresh-randomness source for the first-order threshold Xoodoo datapath. It runs a seedable 64-bit xorshift generator and packs its outputs into 384-bit randomness words. A 2-entry buffer holds completed words, which it delivers to the permutation's `rdi` port over a valid/ready handshake. It sits beside the permutation core in the crypto core and is the transmitter side of the `rdi`/`rdi_valid`/`rdi_ready` interface. Each Xoodoo round consumes two words.

---
 rtl/xoodoo_rdi_pkg.sv | 28 ++
 rtl/xoodoo_xorshift64.sv | 35 +++
 rtl/xoodoo_rdi_gen.sv | 124 ++++++++++++
 tb/tb_xoodoo_rdi_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/xoodoo_rdi_pkg.sv
// Shared constants and the xorshift64 step for the Xoodoo fresh-randomness source.
package xoodoo_rdi_pkg;

  localparam int CHUNK_W = 64;
  localparam int CHUNKS  = 6;
  localparam int RDI_W   = CHUNKS * CHUNK_W;

  localparam logic [63:0] DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15;

  localparam int SH_A = 13;
  localparam int SH_B = 7;
  localparam int SH_C = 17;

  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } lvl_e;

  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

endpackage

// File: rtl/xoodoo_xorshift64.sv
// 64-bit xorshift state register with seed load and zero-seed substitution.
module xoodoo_xorshift64
  import xoodoo_rdi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [63:0] seed_i,
  input  logic        step_i,
  output logic [63:0] x_o
);

  logic [63:0] x_q, x_d;

  // All-zero is a fixed point of xorshift, so it is never allowed into the state.
  always_comb begin
    x_d = x_q;
    if (load_i) begin
      x_d = (seed_i == 64'd0) ? DEFAULT_SEED : seed_i;
    end else if (step_i) begin
      x_d = xs_step(x_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= DEFAULT_SEED;
    end else begin
      x_q <= x_d;
    end
  end

  assign x_o = x_q;

endmodule

// File: rtl/xoodoo_rdi_gen.sv
// Randomness word source: packs xorshift chunks into 384-bit words and serves them
// from a 2-entry FIFO over the rdi valid/ready handshake.
module xoodoo_rdi_gen
  import xoodoo_rdi_pkg::*;
#(
  parameter int RDI_W   = xoodoo_rdi_pkg::RDI_W,
  parameter int CHUNK_W = xoodoo_rdi_pkg::CHUNK_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [63:0]      seed_i,
  input  logic             seed_load_i,
  input  logic             enable_i,
  output logic [RDI_W-1:0] rdi_o,
  output logic             rdi_valid_o,
  input  logic             rdi_ready_i,
  output logic [1:0]       rdi_level_o
);

  localparam logic [2:0] LAST_CHUNK = 3'(CHUNKS - 1);
  localparam int         ASM_W      = RDI_W - CHUNK_W;

  logic [63:0]      x_cur, chunk;
  logic [2:0]       fill_q, fill_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [RDI_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [RDI_W-1:0] push_word;
  lvl_e             lvl_q, lvl_d;
  logic             valid_q, valid_d;
  logic             pop, last, stall, step, push;

  xoodoo_xorshift64 u_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (seed_load_i),
    .seed_i (seed_i),
    .step_i (step),
    .x_o    (x_cur)
  );

  assign chunk     = xs_step(x_cur);
  assign pop       = valid_q & rdi_ready_i;
  assign last      = (fill_q == LAST_CHUNK);
  // Freeze on the final chunk only when no slot can open this cycle.
  assign stall     = last & (lvl_q == LVL_FULL) & ~pop;
  assign step      = enable_i & ~seed_load_i & ~stall;
  assign push      = step & last;
  assign push_word = {chunk, asm_q};

  always_comb begin
    fill_d = fill_q;
    asm_d  = asm_q;
    head_d = head_q;
    tail_d = tail_q;
    lvl_d  = lvl_q;
    if (seed_load_i) begin
      fill_d = 3'd0;
      lvl_d  = LVL_EMPTY;
    end else begin
      if (step) begin
        if (last) begin
          fill_d = 3'd0;
        end else begin
          fill_d = fill_q + 3'd1;
          for (int k = 0; k < CHUNKS - 1; k++) begin
            if (fill_q == 3'(k)) asm_d[k*CHUNK_W +: CHUNK_W] = chunk;
          end
        end
      end
      case ({push, pop})
        2'b10: begin
          if (lvl_q == LVL_EMPTY) begin
            head_d = push_word;
            lvl_d  = LVL_ONE;
          end else begin
            tail_d = push_word;
            lvl_d  = LVL_FULL;
          end
        end
        2'b01: begin
          if (lvl_q == LVL_FULL) begin
            head_d = tail_q;
            lvl_d  = LVL_ONE;
          end else begin
            lvl_d  = LVL_EMPTY;
          end
        end
        2'b11: begin
          if (lvl_q == LVL_FULL) begin
            head_d = tail_q;
            tail_d = push_word;
          end else begin
            head_d = push_word;
          end
        end
        default: ;
      endcase
    end
    valid_d = (lvl_d != LVL_EMPTY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q  <= 3'd0;
      asm_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      lvl_q   <= LVL_EMPTY;
      valid_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      asm_q   <= asm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      lvl_q   <= lvl_d;
      valid_q <= valid_d;
    end
  end

  assign rdi_o       = head_q;
  assign rdi_valid_o = valid_q;
  assign rdi_level_o = lvl_q;

endmodule

// File: tb/tb_xoodoo_rdi_gen.sv
// Directed bench for xoodoo_rdi_gen with an independent xorshift word model.
module tb_xoodoo_rdi_gen;

  localparam logic [63:0] DEF_SEED = 64'h9E37_79B9_7F4A_7C15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  seed;
  logic         seed_load;
  logic         en;
  logic [383:0] rdi;
  logic         valid;
  logic         ready;
  logic [1:0]   level;

  int errors = 0;
  int checks = 0;

  logic [63:0]  mx;
  logic [63:0]  tx;
  logic [383:0] w;

  always #5 clk = ~clk;

  xoodoo_rdi_gen dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .seed_i      (seed),
    .seed_load_i (seed_load),
    .enable_i    (en),
    .rdi_o       (rdi),
    .rdi_valid_o (valid),
    .rdi_ready_i (ready),
    .rdi_level_o (level)
  );

  function automatic logic [63:0] ref_step(input logic [63:0] x);
    logic [63:0] a, b;
    a = x ^ {x[50:0], 13'd0};
    b = a ^ {7'd0, a[63:7]};
    return b ^ {b[46:0], 17'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_seed(input logic [63:0] s);
    mx = (s == 64'd0) ? DEF_SEED : s;
  endtask

  task automatic model_word(output logic [383:0] wo);
    wo = '0;
    for (int k = 0; k < 6; k++) begin
      mx = ref_step(mx);
      wo[k*64 +: 64] = mx;
    end
  endtask

  // Consumes n words with ready held high, comparing each to the model in order.
  task automatic stream_check(input string tag, input int n, input int budget);
    logic [383:0] we;
    bit got;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      for (int c = 0; c < budget; c++) begin
        if (valid) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      checks++;
      assert (got)
      else begin
        errors++;
        $error("FAIL %s_timeout word=%0d observed=no_valid expected=valid", tag, i);
      end
      model_word(we);
      chk(tag, rdi, we);
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    seed      = '0;
    seed_load = 1'b0;
    en        = 1'b0;
    ready     = 1'b0;
    #22;
    chk("rst_valid", 384'(valid), 384'd0);
    chk("rst_level", 384'(level), 384'd0);
    chk("rst_rdi", rdi, 384'd0);
    rst_n = 1'b1;
    tick();

    // Seed 1, continuous enable/ready: one word per 6 cycles.
    seed = 64'd1; seed_load = 1'b1; en = 1'b1; ready = 1'b1;
    tick();
    seed_load = 1'b0;
    model_seed(64'd1);
    repeat (5) tick();
    chk("s1_early_valid", 384'(valid), 384'd0);
    tick();
    chk("s1_valid6", 384'(valid), 384'd1);
    chk("s1_lsb", 384'(rdi[63:0]), 384'h40822041);
    model_word(w);
    chk("s1_word0", rdi, w);
    for (int i = 1; i < 3; i++) begin
      repeat (5) tick();
      chk("s1_gap", 384'(valid), 384'd0);
      tick();
      chk("s1_valid", 384'(valid), 384'd1);
      model_word(w);
      chk("s1_word", rdi, w);
    end

    // Zero seed behaves as DEFAULT_SEED.
    seed = 64'd0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    model_seed(DEF_SEED);
    stream_check("s0_word", 3, 20);

    // Backpressure: fill to two words, freeze, then drain in order.
    ready = 1'b0; seed = 64'h0123_4567_89AB_CDEF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    model_seed(64'h0123_4567_89AB_CDEF);
    tx = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 17; i++) tx = ref_step(tx);
    repeat (11) tick();
    chk("bp_level11", 384'(level), 384'd1);
    tick();
    chk("bp_level12", 384'(level), 384'd2);
    repeat (8) tick();
    chk("bp_x_frozen20", 384'(dut.u_gen.x_o), 384'(tx));
    repeat (10) tick();
    chk("bp_x_frozen30", 384'(dut.u_gen.x_o), 384'(tx));
    chk("bp_level30", 384'(level), 384'd2);
    model_word(w);
    chk("bp_head_w0", rdi, w);
    ready = 1'b1;
    tick();
    chk("bp_pushpop_level", 384'(level), 384'd2);
    stream_check("bp_word", 4, 20);

    // Reload with fill_cnt=3, level=1; then an enable gap mid-fill.
    ready = 1'b0; seed = 64'hA5A5_A5A5_0000_FFFF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    repeat (9) tick();
    chk("rl_level_before", 384'(level), 384'd1);
    seed = 64'h5A5A_0F0F_1234_5678; seed_load = 1'b1; ready = 1'b1;
    tick();
    seed_load = 1'b0;
    model_seed(64'h5A5A_0F0F_1234_5678);
    chk("rl_valid_cleared", 384'(valid), 384'd0);
    chk("rl_level_cleared", 384'(level), 384'd0);
    repeat (2) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (3) tick();
    chk("rl_gap_valid", 384'(valid), 384'd0);
    stream_check("rl_word", 2, 20);

    // Asynchronous reset while a word is offered.
    ready = 1'b0; seed = 64'd7; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    repeat (6) tick();
    chk("ar_valid_pre", 384'(valid), 384'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_async", 384'(valid), 384'd0);
    chk("ar_level_async", 384'(level), 384'd0);
    chk("ar_rdi_async", rdi, 384'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_seed(DEF_SEED);
    ready = 1'b1;
    en = 1'b1;
    stream_check("ar_word", 2, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
